// File: rtl/qsn_shift_scheduler_if.sv
// Signal bundle between the layer-decoder control, the QSN shift scheduler and the permutation datapath.
// inv_dir exists only when QSN_SCHED_INV_SHIFT_EN is defined.
interface qsn_shift_scheduler_if #(
  parameter int SHIFT_W    = 10,
  parameter int CFG_ADDR_W = 7
);
  logic                  cfg_we;
  logic [CFG_ADDR_W-1:0] cfg_addr;
  logic [SHIFT_W-1:0]    cfg_wdata;
  logic                  cfg_err;
  logic                  start;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [SHIFT_W-1:0]    shift_factor;
  logic                  sw_in_valid;
  logic [2:0]            in_layer_idx;
  logic [4:0]            in_col_idx;
  logic                  sw_out_valid;
  logic [2:0]            out_layer_idx;
  logic [4:0]            out_col_idx;
`ifdef QSN_SCHED_INV_SHIFT_EN
  logic                  inv_dir;
`endif

  modport master (
`ifdef QSN_SCHED_INV_SHIFT_EN
    output inv_dir,
`endif
    output cfg_we, cfg_addr, cfg_wdata, start, stall,
    input  cfg_err, busy, done, shift_factor, sw_in_valid, in_layer_idx, in_col_idx,
           sw_out_valid, out_layer_idx, out_col_idx
  );

  modport slave (
`ifdef QSN_SCHED_INV_SHIFT_EN
    input  inv_dir,
`endif
    input  cfg_we, cfg_addr, cfg_wdata, start, stall,
    output cfg_err, busy, done, shift_factor, sw_in_valid, in_layer_idx, in_col_idx,
           sw_out_valid, out_layer_idx, out_col_idx
  );
endinterface

// File: rtl/qsn_shift_scheduler.sv
// Walks the QSN shift-factor table once per decoding iteration and tags network results with layer/column.
// Optional QSN_SCHED_INV_SHIFT_EN issues the inverse shift (L - s) mod L when inv_dir is sampled high at start.
module qsn_shift_scheduler #(
  parameter int PERMUTATION_LENGTH = 765,
  parameter int PIPELINE_STAGES    = 4,
  parameter int LAYER_NUM          = 4,
  parameter int COL_NUM            = 17,
  parameter int SHIFT_W            = 10,
  parameter int CFG_ADDR_W         = 7
) (
  input logic                  sys_clk,
  input logic                  rst,
  qsn_shift_scheduler_if.slave sched
);
  localparam int ENTRY_NUM = LAYER_NUM * COL_NUM;
  localparam int LAYER_W   = 3;
  localparam int COL_W     = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  typedef struct packed {
    logic               valid;
    logic [LAYER_W-1:0] layer;
    logic [COL_W-1:0]   col;
  } tag_t;

  logic [SHIFT_W-1:0]    r_table [ENTRY_NUM];
  state_t                r_state;
  logic [LAYER_W-1:0]    r_layer;
  logic [COL_W-1:0]      r_col;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sw_in_valid;
  logic [SHIFT_W-1:0]    r_shift;
  logic [LAYER_W-1:0]    r_in_layer;
  logic [COL_W-1:0]      r_in_col;
  logic                  r_cfg_err;
  tag_t                  r_pipe [PIPELINE_STAGES];

  logic                  w_start_acc;
  logic                  w_cfg_bad;
  logic                  w_cfg_acc;
  logic                  w_last_col;
  logic                  w_last_entry;
  logic                  w_drain_empty;
  logic [CFG_ADDR_W-1:0] w_rd_addr;
  logic [SHIFT_W-1:0]    w_table_val;
  logic [SHIFT_W-1:0]    w_issue_shift;

  assign w_start_acc = (r_state == ST_IDLE) && sched.start;
  assign w_cfg_bad   = sched.cfg_we &&
                       (r_busy ||
                        (sched.cfg_addr >= CFG_ADDR_W'(ENTRY_NUM)) ||
                        (sched.cfg_wdata >= SHIFT_W'(PERMUTATION_LENGTH)));
  assign w_cfg_acc   = sched.cfg_we && !w_cfg_bad;

  assign w_last_col   = (r_col == COL_W'(COL_NUM - 1));
  assign w_last_entry = w_last_col && (r_layer == LAYER_W'(LAYER_NUM - 1));
  assign w_rd_addr    = CFG_ADDR_W'(r_layer) * CFG_ADDR_W'(COL_NUM) + CFG_ADDR_W'(r_col);
  assign w_table_val  = r_table[w_rd_addr];

`ifdef QSN_SCHED_INV_SHIFT_EN
  logic r_inv_dir;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_inv_dir <= 1'b0;
    end else if (w_start_acc) begin
      r_inv_dir <= sched.inv_dir;
    end
  end

  // Zero is its own inverse; every other value maps to L - s.
  assign w_issue_shift = (r_inv_dir && (w_table_val != '0))
                         ? SHIFT_W'(PERMUTATION_LENGTH) - w_table_val
                         : w_table_val;
`else
  assign w_issue_shift = w_table_val;
`endif

  // NOTE: the table is plain storage with no reset branch; contents survive rst and stay undefined until written.
  always_ff @(posedge sys_clk) begin
    if (w_cfg_acc) begin
      r_table[sched.cfg_addr] <= sched.cfg_wdata;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else if (w_cfg_bad) begin
      r_cfg_err <= 1'b1;
    end else if (w_start_acc) begin
      r_cfg_err <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_layer       <= '0;
      r_col         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_sw_in_valid <= 1'b0;
      r_shift       <= '0;
      r_in_layer    <= '0;
      r_in_col      <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
      r_done        <= 1'b0;
      r_sw_in_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sched.start) begin
            r_state <= ST_ISSUE;
            r_busy  <= 1'b1;
            r_layer <= '0;
            r_col   <= '0;
          end
        end
        ST_ISSUE: begin
          if (!sched.stall) begin
            r_sw_in_valid <= 1'b1;
            r_shift       <= w_issue_shift;
            r_in_layer    <= r_layer;
            r_in_col      <= r_col;
            if (w_last_entry) begin
              r_state <= ST_DRAIN;
              r_layer <= '0;
              r_col   <= '0;
            end else if (w_last_col) begin
              r_col   <= '0;
              r_layer <= r_layer + LAYER_W'(1);
            end else begin
              r_col   <= r_col + COL_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_empty) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The network is free-running, so the tag pipe shifts every cycle, stalled or not.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= {r_sw_in_valid, r_in_layer, r_in_col};
      for (int i = 1; i < PIPELINE_STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  // Empty after this edge: the final stage is the only one allowed to still hold a valid entry.
  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned and infers a latch.
    w_drain_empty = !r_sw_in_valid;
    for (int i = 0; i < PIPELINE_STAGES - 1; i++) begin
      if (r_pipe[i].valid) begin
        w_drain_empty = 1'b0;
      end
    end
  end

  assign sched.cfg_err       = r_cfg_err;
  assign sched.busy          = r_busy;
  assign sched.done          = r_done;
  assign sched.shift_factor  = r_shift;
  assign sched.sw_in_valid   = r_sw_in_valid;
  assign sched.in_layer_idx  = r_in_layer;
  assign sched.in_col_idx    = r_in_col;
  assign sched.sw_out_valid  = r_pipe[PIPELINE_STAGES-1].valid;
  assign sched.out_layer_idx = r_pipe[PIPELINE_STAGES-1].layer;
  assign sched.out_col_idx   = r_pipe[PIPELINE_STAGES-1].col;

endmodule

// File: tb/tb_qsn_shift_scheduler.sv
// Self-checking bench for qsn_shift_scheduler: records every issue/output/done event and compares whole
// iterations against a table-plus-stall-pattern reference model.
module tb_qsn_shift_scheduler;
  localparam int PERM_LEN = 765;
  localparam int ENTRIES  = 68;
  localparam int COLS     = 17;
  localparam int LAT      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qsn_shift_scheduler_if #(.SHIFT_W(10), .CFG_ADDR_W(7)) bus ();

  qsn_shift_scheduler dut (
    .sys_clk (clk),
    .rst     (rst),
    .sched   (bus)
  );

  typedef struct {
    int cyc;
    int shift;
    int layer;
    int col;
  } rec_t;

  rec_t issue_q[$];
  rec_t out_q[$];
  int   done_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  int   tbl[ENTRIES];
  bit   model_inv = 1'b0;
  bit   stall_pat[512];
  int   inj_start_at = -1;
  int   inj_write_at = -1;
  int   inj_addr     = 0;
  int   inj_data     = 0;

  // Event recorder: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus.sw_in_valid === 1'b1)
      issue_q.push_back('{cyc, int'(bus.shift_factor), int'(bus.in_layer_idx), int'(bus.in_col_idx)});
    if (bus.sw_out_valid === 1'b1)
      out_q.push_back('{cyc, 0, int'(bus.out_layer_idx), int'(bus.out_col_idx)});
    if (bus.done === 1'b1)
      done_q.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [30:0] out_vec();
    return {bus.busy, bus.done, bus.sw_in_valid, bus.sw_out_valid, bus.cfg_err, bus.shift_factor,
            bus.in_layer_idx, bus.in_col_idx, bus.out_layer_idx, bus.out_col_idx};
  endfunction

  task automatic clear_stall();
    for (int j = 0; j < 512; j++) stall_pat[j] = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 7'(addr);
    bus.cfg_wdata = 10'(data);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    if (addr < ENTRIES && data < PERM_LEN) tbl[addr] = data;
  endtask

  // One iteration: start at a falling edge, stall_pat[j] drives the j-th rising edge after the start edge.
  task automatic run_iter(output int st_cyc);
    bit seen;
    issue_q.delete();
    out_q.delete();
    done_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    st_cyc    = cyc;
    if (inj_write_at == 0) begin
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 7'(inj_addr);
      bus.cfg_wdata = 10'(inj_data);
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
`ifdef QSN_SCHED_INV_SHIFT_EN
    bus.inv_dir = 1'b0;
`endif
    total++;
    if (bus.busy !== 1'b1 || bus.cfg_err !== 1'b0) begin
      $display("FAIL run_start: busy=%b cfg_err=%b, expected busy=1 cfg_err=0", bus.busy, bus.cfg_err);
      bad++;
    end
    seen = 1'b0;
    for (int j = 1; j <= 300 && !seen; j++) begin
      bus.stall     = stall_pat[j];
      bus.start     = (j == inj_start_at);
      bus.cfg_we    = (j == inj_write_at);
      bus.cfg_addr  = 7'(inj_addr);
      bus.cfg_wdata = 10'(inj_data);
      @(negedge clk);
      seen = (done_q.size() > 0);
    end
    bus.stall  = 1'b0;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    total++;
    if (!seen) begin
      $display("FAIL run_timeout: no done within 300 cycles");
      bad++;
    end else if (bus.busy !== 1'b0) begin
      $display("FAIL run_done_busy: busy=%b during done, expected 0", bus.busy);
      bad++;
    end
  endtask

  // Reference: entry k issues at the k-th unstalled edge, emerges LAT cycles later, done one cycle after.
  task automatic verify_run(input string name, input int st);
    int exp_c[ENTRIES];
    int k;
    int es;
    k = 0;
    for (int j = 1; j < 512 && k < ENTRIES; j++) begin
      if (!stall_pat[j]) begin
        exp_c[k] = st + 1 + j;
        k++;
      end
    end
    total++;
    if (issue_q.size() != ENTRIES) begin
      $display("FAIL %s issue_count: got %0d, expected %0d", name, issue_q.size(), ENTRIES);
      bad++;
    end
    for (int i = 0; i < ENTRIES && i < issue_q.size(); i++) begin
      es = tbl[i];
      if (model_inv && es != 0) es = PERM_LEN - es;
      total++;
      if (issue_q[i].cyc != exp_c[i] || issue_q[i].shift != es ||
          issue_q[i].layer != i / COLS || issue_q[i].col != i % COLS) begin
        $display("FAIL %s issue[%0d]: got cyc=%0d shift=%0d tag=(%0d,%0d), expected cyc=%0d shift=%0d tag=(%0d,%0d)",
                 name, i, issue_q[i].cyc - st, issue_q[i].shift, issue_q[i].layer, issue_q[i].col,
                 exp_c[i] - st, es, i / COLS, i % COLS);
        bad++;
      end
    end
    total++;
    if (out_q.size() != ENTRIES) begin
      $display("FAIL %s out_count: got %0d, expected %0d", name, out_q.size(), ENTRIES);
      bad++;
    end
    for (int i = 0; i < ENTRIES && i < out_q.size(); i++) begin
      total++;
      if (out_q[i].cyc != exp_c[i] + LAT || out_q[i].layer != i / COLS || out_q[i].col != i % COLS) begin
        $display("FAIL %s out[%0d]: got cyc=%0d tag=(%0d,%0d), expected cyc=%0d tag=(%0d,%0d)",
                 name, i, out_q[i].cyc - st, out_q[i].layer, out_q[i].col, exp_c[i] + LAT - st, i / COLS, i % COLS);
        bad++;
      end
    end
    total++;
    if (done_q.size() != 1 || done_q[0] != exp_c[ENTRIES-1] + LAT + 1) begin
      $display("FAIL %s done: got count=%0d first_at=%0d, expected count=1 at=%0d", name, done_q.size(),
               (done_q.size() > 0) ? done_q[0] - st : -1, exp_c[ENTRIES-1] + LAT + 1 - st);
      bad++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (out_vec() !== '0) begin
      $display("FAIL reset_hold: outputs=%h, expected 0", out_vec());
      bad++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (out_vec() !== '0) begin
      $display("FAIL reset_release: outputs=%h, expected 0", out_vec());
      bad++;
    end
  endtask

  task automatic test_linear();
    int st;
    for (int k = 0; k < ENTRIES; k++) cfg_write(k, k * 11);
    clear_stall();
    run_iter(st);
    verify_run("linear", st);
    total++;
    if (issue_q.size() < 1 || issue_q[0].cyc - st != 2 || done_q.size() < 1 || done_q[0] - st != 74) begin
      $display("FAIL linear_latency: first_issue=%0d done=%0d, expected 2 and 74",
               (issue_q.size() > 0) ? issue_q[0].cyc - st : -1, (done_q.size() > 0) ? done_q[0] - st : -1);
      bad++;
    end
  endtask

  task automatic test_stall();
    int st;
    int n220;
    clear_stall();
    for (int j = 21; j <= 23; j++) stall_pat[j] = 1'b1;
    run_iter(st);
    verify_run("stall", st);
    n220 = 0;
    foreach (issue_q[i]) if (issue_q[i].shift == 220) n220++;
    total++;
    if (n220 != 1 || issue_q.size() < 21 || issue_q[20].cyc - st != 25) begin
      $display("FAIL stall_entry20: count=%0d at=%0d, expected count=1 at=25", n220,
               (issue_q.size() > 20) ? issue_q[20].cyc - st : -1);
      bad++;
    end
    total++;
    if (done_q.size() < 1 || done_q[0] - st != 77) begin
      $display("FAIL stall_done: got %0d, expected 77", (done_q.size() > 0) ? done_q[0] - st : -1);
      bad++;
    end
    clear_stall();
  endtask

  task automatic test_cfg_err();
    int st;
    cfg_write(67, 764);
    total++;
    if (bus.cfg_err !== 1'b0) begin
      $display("FAIL cfg_legal_edge: cfg_err=%b, expected 0", bus.cfg_err);
      bad++;
    end
    cfg_write(5, 765);
    total++;
    if (bus.cfg_err !== 1'b1) begin
      $display("FAIL cfg_bad_data: cfg_err=%b, expected 1", bus.cfg_err);
      bad++;
    end
    cfg_write(68, 123);
    total++;
    if (bus.cfg_err !== 1'b1) begin
      $display("FAIL cfg_bad_addr: cfg_err=%b, expected 1", bus.cfg_err);
      bad++;
    end
    run_iter(st);
    verify_run("cfg_err", st);
  endtask

  task automatic test_random();
    int st;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < ENTRIES; k++) cfg_write(k, int'($urandom_range(0, PERM_LEN - 1)));
      for (int j = 0; j < 512; j++) stall_pat[j] = ($urandom_range(0, 9) < 3);
      run_iter(st);
      verify_run("random", st);
    end
    clear_stall();
  endtask

  task automatic test_reset_mid();
    bit hit;
    int st;
    clear_stall();
    issue_q.delete();
    out_q.delete();
    done_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int j = 0; j < 100 && !hit; j++) begin
      @(negedge clk);
      hit = (issue_q.size() == 31);
    end
    total++;
    if (!hit || issue_q[30].layer != 1 || issue_q[30].col != 13) begin
      $display("FAIL midrst_reach: issued=%0d, expected entry 30 at tag (1,13)", issue_q.size());
      bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (out_vec() !== '0) begin
      $display("FAIL midrst_outputs: outputs=%h, expected 0", out_vec());
      bad++;
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (done_q.size() != 0 || issue_q.size() != 31) begin
      $display("FAIL midrst_abort: dones=%0d issued=%0d, expected 0 and 31", done_q.size(), issue_q.size());
      bad++;
    end
    run_iter(st);
    verify_run("after_reset", st);
  endtask

  task automatic test_ignore();
    int st;
    clear_stall();
    inj_start_at = 10;
    inj_write_at = 12;
    inj_addr     = 3;
    inj_data     = 5;
    run_iter(st);
    inj_start_at = -1;
    inj_write_at = -1;
    total++;
    if (bus.cfg_err !== 1'b1) begin
      $display("FAIL ignore_cfg_err: cfg_err=%b, expected 1", bus.cfg_err);
      bad++;
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    verify_run("ignore", st);
    total++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL ignore_done_start: busy=%b, expected 0", bus.busy);
      bad++;
    end
  endtask

  task automatic test_back_to_back_write_start();
    int st;
    clear_stall();
    inj_write_at = 0;
    inj_addr     = 0;
    inj_data     = int'($urandom_range(1, PERM_LEN - 1));
    tbl[0]       = inj_data;
    run_iter(st);
    inj_write_at = -1;
    verify_run("write_start", st);
    total++;
    if (issue_q.size() < 1 || issue_q[0].shift != inj_data) begin
      $display("FAIL write_start_first: shift=%0d, expected %0d",
               (issue_q.size() > 0) ? issue_q[0].shift : -1, inj_data);
      bad++;
    end
  endtask

`ifdef QSN_SCHED_INV_SHIFT_EN
  task automatic test_inv_shift();
    int st;
    clear_stall();
    cfg_write(0, 0);
    cfg_write(1, 100);
    bus.inv_dir = 1'b1;
    model_inv   = 1'b1;
    run_iter(st);
    verify_run("inverse", st);
    model_inv = 1'b0;
    total++;
    if (issue_q.size() < 2 || issue_q[0].shift != 0 || issue_q[1].shift != 665) begin
      $display("FAIL inverse_first_two: got %0d,%0d expected 0,665",
               (issue_q.size() > 0) ? issue_q[0].shift : -1, (issue_q.size() > 1) ? issue_q[1].shift : -1);
      bad++;
    end
  endtask
`endif

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
`ifdef QSN_SCHED_INV_SHIFT_EN
    bus.inv_dir   = 1'b0;
`endif
    clear_stall();
    test_reset();
    test_linear();
    test_stall();
    test_cfg_err();
    test_random();
    test_reset_mid();
    test_ignore();
    test_back_to_back_write_start();
`ifdef QSN_SCHED_INV_SHIFT_EN
    test_inv_shift();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qsn_shift_scheduler.md
Name: qsn_shift_scheduler

Overview:
- Sequences the 765-wide QSN permutation network through one decoding iteration: LAYER_NUM layers × COL_NUM submatrix columns.
- Holds a programmable shift-factor table and issues one shift_factor per cycle together with a load strobe, honouring downstream stall.
- Tracks the network's fixed pipeline latency so result-valid, layer/column tags and done line up with sw_out data.
- Sits between the layer decoder control FSM and the permutation datapath.

Parameters:
PERMUTATION_LENGTH, 765, network length; legal shifts are 0..764
PIPELINE_STAGES, 4, cycles from sw_in load to sw_out valid
LAYER_NUM, 4, layers per iteration
COL_NUM, 17, submatrix columns per layer
SHIFT_W, 10, shift_factor width
CFG_ADDR_W, 7, table address width (≥ clog2(LAYER_NUM*COL_NUM))

Ports:
sys_clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  table write strobe
cfg_addr  in  CFG_ADDR_W  entry index = layer*COL_NUM+col
cfg_wdata  in  SHIFT_W  shift value
cfg_err  out  1  sticky config error
start  in  1  one-cycle iteration start pulse
stall  in  1  downstream backpressure; blocks issue
busy  out  1  iteration in progress
done  out  1  one-cycle completion pulse
shift_factor  out  SHIFT_W  to network shift_factor input
sw_in_valid  out  1  sw_in load strobe for this cycle
in_layer_idx  out  3  layer of issued entry
in_col_idx  out  5  column of issued entry
sw_out_valid  out  1  network output valid
out_layer_idx  out  3  layer tag aligned to sw_out_valid
out_col_idx  out  5  column tag aligned to sw_out_valid

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, tag pipeline cleared. Table contents unaffected by reset and undefined until written. Reset mid-iteration aborts immediately; no done is produced.
- Table writes: accepted only when busy=0, cfg_addr < LAYER_NUM*COL_NUM and cfg_wdata < PERMUTATION_LENGTH. Any violation drops the write and sets cfg_err. cfg_err clears on rst or an accepted start.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 moves to ISSUE and clears layer/col counters; busy=1 from the next cycle.
- ISSUE, stall=0 at the edge: registers sw_in_valid=1, shift_factor=table[layer*COL_NUM+col] and the index tags. Col increments; at COL_NUM-1 it wraps to 0 and layer increments. After the entry (LAYER_NUM-1, COL_NUM-1) the FSM moves to DRAIN.
- ISSUE, stall=1: sw_in_valid=0; shift_factor and tags hold their last value; counters hold.
- First sw_in_valid appears the cycle after start+1 edge, i.e. 2 cycles after the start pulse.
- Tag pipeline: {valid, layer, col} is delayed exactly PIPELINE_STAGES cycles. It shifts every cycle regardless of stall, because the network is free-running. sw_out_valid = sw_in_valid delayed PIPELINE_STAGES cycles.
- DRAIN: waits until the tag pipeline is empty, then moves to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. done is therefore one cycle after the final sw_out_valid.
- start while busy=1, or in the DONE cycle: ignored.
- start and cfg_we in the same IDLE cycle: the write is applied and the run starts. The first issue reads the updated table.
- Unstalled run length: start to done = LAYER_NUM*COL_NUM + PIPELINE_STAGES + 2 cycles (74 with defaults).

Optional Feature:
QSN_SCHED_INV_SHIFT_EN:
- Defined: adds input inv_dir (1 bit), sampled with an accepted start and held for the run.
- When inv_dir=1, every issued shift is (PERMUTATION_LENGTH - s) mod PERMUTATION_LENGTH, so 0 maps to 0. This performs the inverse (de-)permutation using the same table.
- Undefined: the port is absent and the table value is always issued unchanged.

Test Plan:
- Write table[k]=k*11 for k=0..67, pulse start, stall=0 → sw_in_valid high for 68 consecutive cycles. Values are shift_factor 0, 11, …, 737 with tags (0,0)…(3,16). sw_out_valid follows 4 cycles later. done occurs 74 cycles after start.
- Same run with stall=1 for 3 cycles at entry 20 → 3-cycle gap in sw_in_valid. Entry 20 is issued exactly once with shift 220. Ordering is preserved. done is delayed by exactly 3 cycles.
- cfg_wdata=765 at addr 5, then cfg_addr=68 → both writes dropped, table[5] unchanged, cfg_err=1. The next start clears cfg_err.
- Assert rst at issue entry 30 → all outputs 0 on the next sample. No done is produced. A subsequent start runs the full 68 entries.
- start pulsed again during ISSUE, and cfg_we during ISSUE → both ignored. Only one done is produced; cfg_err is set by the write.
- (QSN_SCHED_INV_SHIFT_EN) table[1]=100, table[0]=0, inv_dir=1 → issued shifts 0 and 665.
